// File: rtl/filter_pkg.sv
// Shared definitions for the 3x3 max/min filter datapath (line buffer and compare window).
// Holds the default pixel geometry, the lane ordering of a packed column and clogb2.
// No logic; imported by every filter block.
package filter_pkg;

   localparam int PIXEL_WIDTH_DEF = 14;
   localparam int LINE_NUM_DEF    = 3;

   // Lane positions inside a packed column: lane k occupies [k*PW +: PW].
   localparam int LANE_CUR   = 0;
   localparam int LANE_PREV1 = 1;
   localparam int LANE_PREV2 = 2;

   // Number of bits needed to hold 'value' (minimum 1).
   function automatic int clogb2(input int value);
      int v;
      int n;
      v = value;
      n = 0;
      while (v > 0) begin
         n = n + 1;
         v = v >> 1;
      end
      if (n == 0) begin
         n = 1;
      end
      return n;
   endfunction

endpackage

// File: rtl/line_buffer_3row_if.sv
// Pixel-in / column-out stream bundle between a raster source, the line buffer and the 3x3 window.
// Wires only, no latency.
// No backpressure: the valid strobes qualify data, and the source stalls by dropping din_valid.
interface line_buffer_3row_if #(
   parameter int PIXEL_WIDTH = 14,
   parameter int LINE_NUM    = 3
);
   logic                            sof;
   logic [PIXEL_WIDTH-1:0]          data_in;
   logic                            din_valid;
   logic [PIXEL_WIDTH*LINE_NUM-1:0] data_out;
   logic                            dout_valid;

   modport master (
      output sof, data_in, din_valid,
      input  data_out, dout_valid
   );

   modport slave (
      input  sof, data_in, din_valid,
      output data_out, dout_valid
   );
endinterface

// File: rtl/line_delay.sv
// One image row of pixel storage, addressed by column (LUT RAM).
// Asynchronous read, write on the clock edge when en is high, so a read sees the old word.
// No backpressure; en gates the write.
module line_delay #(
   parameter int DEPTH = 128,
   parameter int WIDTH = 14,
   parameter int AW    = 7
) (
   input  logic             clk,
   input  logic             en,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] mem [DEPTH];

   assign dout = mem[addr];

   // Store the incoming pixel at its column; contents are never reset.
   always_ff @(posedge clk) begin
      if (en) begin
         mem[addr] <= din;
      end
   end

endmodule

// File: rtl/line_buffer_3row.sv
// Raster pixel stream in, vertically aligned 3-pixel column (rows r, r-1, r-2) out.
// Latency 1 cycle from accepted pixel to column; optional BORDER_REPLICATE_EN also emits rows 0/1.
// No backpressure; nothing advances while din_valid is low and data_out then holds.
module line_buffer_3row
   import filter_pkg::*;
#(
   parameter int LINE_NUM     = LINE_NUM_DEF,
   parameter int PIXEL_WIDTH  = PIXEL_WIDTH_DEF,
   parameter int IMAGE_WIDTH  = 128,
   parameter int IMAGE_HEIGHT = 128
) (
   input logic               clk,
   input logic               arstn,
   line_buffer_3row_if.slave px
);

   localparam int PW = PIXEL_WIDTH;
   localparam int CW = clogb2(IMAGE_WIDTH - 1);
   localparam int RW = clogb2(IMAGE_HEIGHT - 1);

   logic [CW-1:0]          col_cnt;
   logic [RW-1:0]          row_cnt;
   logic [CW-1:0]          cur_col;
   logic [RW-1:0]          cur_row;
   logic [PW-1:0]          prev1;
   logic [PW-1:0]          prev2;
   logic [PW*LINE_NUM-1:0] col_dat;
   logic                   col_vld;

   // An accepted sof forces this pixel to the frame origin whatever the counters say.
   always_comb begin
      cur_col = col_cnt;
      cur_row = row_cnt;
      if (px.sof) begin
         cur_col = '0;
         cur_row = '0;
      end
   end

   // Raster position of the next pixel, advanced only on accepted pixels.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         col_cnt <= '0;
         row_cnt <= '0;
      end else if (px.din_valid) begin
         if (cur_col == CW'(IMAGE_WIDTH - 1)) begin
            col_cnt <= '0;
            if (cur_row == RW'(IMAGE_HEIGHT - 1)) begin
               row_cnt <= '0;
            end else begin
               row_cnt <= cur_row + RW'(1);
            end
         end else begin
            col_cnt <= cur_col + CW'(1);
            row_cnt <= cur_row;
         end
      end
   end

   // stage0 holds row r-1 and takes the new pixel; stage1 holds row r-2 and takes stage0's old word.
   line_delay #(.DEPTH(IMAGE_WIDTH), .WIDTH(PW), .AW(CW)) u_stage0 (
      .clk  (clk),
      .en   (px.din_valid),
      .addr (cur_col),
      .din  (px.data_in),
      .dout (prev1)
   );

   line_delay #(.DEPTH(IMAGE_WIDTH), .WIDTH(PW), .AW(CW)) u_stage1 (
      .clk  (clk),
      .en   (px.din_valid),
      .addr (cur_col),
      .din  (prev1),
      .dout (prev2)
   );

   // Assemble the column; the two stored rows only belong to this frame from row 2 onward.
   always_comb begin
      col_dat = '0;
      col_dat[LANE_CUR*PW   +: PW] = px.data_in;
      col_dat[LANE_PREV1*PW +: PW] = prev1;
      col_dat[LANE_PREV2*PW +: PW] = prev2;
      col_vld = (cur_row >= RW'(2));
`ifdef BORDER_REPLICATE_EN
      // Top border: missing rows are copied from the nearest real row of this frame.
      if (cur_row == RW'(0)) begin
         col_dat[LANE_PREV1*PW +: PW] = px.data_in;
         col_dat[LANE_PREV2*PW +: PW] = px.data_in;
      end else if (cur_row == RW'(1)) begin
         col_dat[LANE_PREV2*PW +: PW] = prev1;
      end
      col_vld = 1'b1;
`endif
   end

   // Output register: capture on accepted pixels, hold data and drop valid otherwise.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         px.data_out   <= '0;
         px.dout_valid <= 1'b0;
      end else if (px.din_valid) begin
         px.data_out   <= col_dat;
         px.dout_valid <= col_vld;
      end else begin
         px.dout_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_line_buffer_3row.sv
// Self-checking bench for line_buffer_3row with an 8x4 image, pixel value = base + 16*row + col.
// Expected columns come from a table built from the pixel formula; a monitor checks hold/valid rules.
// Covers reset, continuous, stalled, back-to-back, mid-row sof and mid-frame reset.
module tb_line_buffer_3row;
   import filter_pkg::*;

   localparam int PW = 14;
   localparam int W  = 8;
   localparam int H  = 4;
`ifdef BORDER_REPLICATE_EN
   localparam int FIRST_ROW = 0;
`else
   localparam int FIRST_ROW = 2;
`endif
   localparam int NOUT = (H - FIRST_ROW) * W;

   typedef struct {
      int              row;
      int              col;
      logic [3*PW-1:0] exp_dat;
      int              exp_pos;
   } vec_t;

   logic clk = 1'b0;
   logic arstn;
   always #5 clk = ~clk;

   line_buffer_3row_if #(.PIXEL_WIDTH(PW), .LINE_NUM(3)) bus ();

   line_buffer_3row #(
      .LINE_NUM     (3),
      .PIXEL_WIDTH  (PW),
      .IMAGE_WIDTH  (W),
      .IMAGE_HEIGHT (H)
   ) dut (
      .clk   (clk),
      .arstn (arstn),
      .px    (bus)
   );

   vec_t            vec [NOUT];
   int              n_checks = 0;
   int              n_fail   = 0;
   logic [3*PW-1:0] q_dat [$];
   int              q_pos [$];
   int              acc_cnt  = 0;
   bit              prev_acc = 1'b0;
   logic [3*PW-1:0] last_dat = '0;

   function automatic logic [PW-1:0] pix(input int r, input int c, input int base);
      return PW'(base + 16 * r + c);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: collect columns with their accepted-pixel position, and check idle cycles.
   always @(negedge clk) begin
      if (!arstn) begin
         prev_acc = 1'b0;
         last_dat = '0;
      end else begin
         if (prev_acc) acc_cnt++;
         if (!prev_acc) begin
            chk("idle_valid_low", 64'(bus.dout_valid), 64'd0);
            chk("idle_hold", 64'(bus.data_out), 64'(last_dat));
         end else if (bus.dout_valid) begin
            q_dat.push_back(bus.data_out);
            q_pos.push_back(acc_cnt);
         end
         last_dat = bus.data_out;
         prev_acc = bus.din_valid;
      end
   end

   task automatic clr();
      q_dat.delete();
      q_pos.delete();
      acc_cnt = 0;
   endtask

   task automatic drive(input bit v, input bit s, input logic [PW-1:0] d);
      @(posedge clk);
      #2;
      bus.din_valid = v;
      bus.sof       = s;
      bus.data_in   = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
   endtask

   task automatic send_pixels(input int count, input int base, input bit sof_first, input int stall_pct);
      for (int i = 0; i < count; i++) begin
         while (int'($urandom_range(99)) < stall_pct)
            drive(1'b0, 1'($urandom_range(1)), PW'($urandom));
         drive(1'b1, sof_first && (i == 0), pix((i / W) % H, i % W, base));
      end
   endtask

   task automatic check_frame(input string name, input int qoff, input int base_pos);
      for (int k = 0; k < NOUT; k++) begin
         if (qoff + k < q_dat.size()) begin
            chk({name, "_dat"}, 64'(q_dat[qoff + k]), 64'(vec[k].exp_dat));
            chk({name, "_pos"}, 64'(q_pos[qoff + k]), 64'(base_pos + vec[k].exp_pos));
         end
      end
   endtask

   initial begin
      logic [3*PW-1:0] first_exp;
      logic [3*PW-1:0] last_exp;
      int idx;

      // Expected-column table from the pixel formula.
      idx = 0;
      for (int r = FIRST_ROW; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            logic [PW-1:0] cur, p1, p2;
            cur = pix(r, c, 0);
            p1  = (r >= 1) ? pix(r - 1, c, 0) : cur;
            p2  = (r >= 2) ? pix(r - 2, c, 0) : p1;
            vec[idx].row     = r;
            vec[idx].col     = c;
            vec[idx].exp_dat = {p2, p1, cur};
            vec[idx].exp_pos = r * W + c + 1;
            idx++;
         end
      end

      // Reset state.
      arstn = 1'b0;
      bus.din_valid = 1'b0;
      bus.sof       = 1'b0;
      bus.data_in   = '0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_dout_valid", 64'(bus.dout_valid), 64'd0);
      chk("rst_data_out", 64'(bus.data_out), 64'd0);
      arstn = 1'b1;
      idle(2);

      // Continuous frame.
      clr();
      send_pixels(W * H, 0, 1'b1, 0);
      idle(3);
      chk("cont_count", 64'(q_dat.size()), 64'(NOUT));
      check_frame("cont", 0, 0);
`ifdef BORDER_REPLICATE_EN
      first_exp = {14'h000, 14'h000, 14'h000};
      if (q_dat.size() > 11) chk("border_r1c3", 64'(q_dat[11]), 64'({14'h003, 14'h003, 14'h013}));
`else
      first_exp = {14'h000, 14'h010, 14'h020};
`endif
      last_exp = {14'h017, 14'h027, 14'h037};
      if (q_dat.size() > 0) begin
         chk("cont_first", 64'(q_dat[0]), 64'(first_exp));
         chk("cont_last", 64'(q_dat[q_dat.size() - 1]), 64'(last_exp));
      end

      // Random 50% stalls, with random sof on idle cycles that must be ignored.
      clr();
      send_pixels(W * H, 0, 1'b1, 50);
      idle(3);
      chk("stall_count", 64'(q_dat.size()), 64'(NOUT));
      check_frame("stall", 0, 0);

      // Back-to-back frames.
      clr();
      send_pixels(W * H, 0, 1'b1, 0);
      send_pixels(W * H, 0, 1'b1, 0);
      idle(3);
      chk("b2b_count", 64'(q_dat.size()), 64'(2 * NOUT));
      check_frame("b2b_f1", 0, 0);
      check_frame("b2b_f2", NOUT, W * H);

      // sof at row 1 col 5 of a frame with different pixel values.
      clr();
      send_pixels(W + 5, 12'h300, 1'b1, 0);
      send_pixels(W * H, 0, 1'b1, 0);
      idle(3);
`ifdef BORDER_REPLICATE_EN
      chk("sofmid_count", 64'(q_dat.size()), 64'(W + 5 + NOUT));
      check_frame("sofmid", W + 5, W + 5);
`else
      chk("sofmid_count", 64'(q_dat.size()), 64'(NOUT));
      check_frame("sofmid", 0, W + 5);
`endif

      // Asynchronous reset in the middle of row 2.
      clr();
      send_pixels(2 * W + 4, 0, 1'b1, 0);
      @(posedge clk);
      #3;
      chk("prerst_data", 64'(bus.data_out), 64'({14'h003, 14'h013, 14'h023}));
      chk("prerst_valid", 64'(bus.dout_valid), 64'd1);
      bus.din_valid = 1'b0;
      arstn = 1'b0;
      #1;
      chk("midrst_data", 64'(bus.data_out), 64'd0);
      chk("midrst_valid", 64'(bus.dout_valid), 64'd0);
      @(posedge clk);
      #3;
      arstn = 1'b1;
      clr();
      send_pixels(W * H, 0, 1'b0, 0);
      idle(3);
      chk("rst_restart_count", 64'(q_dat.size()), 64'(NOUT));
      check_frame("rst_restart", 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
